// File: rtl/fetch_ctrl.sv
// PC sequencer and fetch controller for the dual-issue fetch stage.
// Selects the next bundle address and drives slot valids, fetch acceptance and flushes.
module fetch_ctrl #(
  parameter logic [31:0] PC_START = 32'h00400020,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             br_taken,
  input  logic [31:0]      br_target,
  input  logic             jmp_valid,
  input  logic [31:0]      jmp_target,
  input  logic             halt,
  input  logic             imem_ready,
  output logic [31:0]      pc,
  output logic [31:0]      imem_addr,
  output logic             slot0_valid,
  output logic             slot1_valid,
  output logic             fetch_valid,
  output logic             flush_if_id,
  output logic             flush_id_ex,
  output logic             misalign_err,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] bundle_cnt
);

  typedef enum logic [1:0] {
    BOOT      = 2'd0,
    FETCH     = 2'd1,
    MISS_WAIT = 2'd2,
    HALTED    = 2'd3
  } state_t;

  state_t      cur_state;
  state_t      nxt_state;
  logic [31:0] pc_q;
  logic [31:0] pc_nxt;
  logic [31:0] seq_pc;
  logic        jmp_eff;
  logic        err_set;

  // A jump is only honoured when the hazard unit is not holding the front end
  assign jmp_eff   = jmp_valid & ~stall;
  assign seq_pc    = {pc_q[31:3], 3'b000} + 32'd8;
  assign pc        = pc_q;
  assign imem_addr = {pc_q[31:3], 3'b000};
  assign state     = cur_state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cur_state    <= BOOT;
      pc_q         <= PC_START;
      bundle_cnt   <= '0;
      misalign_err <= 1'b0;
    end else begin
      cur_state    <= nxt_state;
      pc_q         <= pc_nxt;
      misalign_err <= misalign_err | err_set;
      if (fetch_valid) begin
        bundle_cnt <= bundle_cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    nxt_state   = cur_state;
    pc_nxt      = pc_q;
    fetch_valid = 1'b0;
    slot0_valid = 1'b0;
    slot1_valid = 1'b0;
    flush_if_id = 1'b0;
    flush_id_ex = 1'b0;
    err_set     = 1'b0;

    case (cur_state)
      BOOT: begin
        nxt_state = FETCH;
      end

      // FETCH and MISS_WAIT share outputs; the miss state only remembers the wait
      FETCH, MISS_WAIT: begin
        slot0_valid = ~pc_q[2];
        slot1_valid = 1'b1;
        fetch_valid = imem_ready & ~stall & ~br_taken & ~jmp_eff & ~halt;
        if (br_taken) begin
          flush_if_id = 1'b1;
          flush_id_ex = 1'b1;
          pc_nxt      = {br_target[31:2], 2'b00};
          err_set     = |br_target[1:0];
          nxt_state   = FETCH;
        end else if (jmp_eff) begin
          flush_if_id = 1'b1;
          pc_nxt      = {jmp_target[31:2], 2'b00};
          err_set     = |jmp_target[1:0];
          nxt_state   = FETCH;
        end else if (halt) begin
          nxt_state = HALTED;
        end else if (!imem_ready) begin
          nxt_state = MISS_WAIT;
        end else if (stall) begin
          nxt_state = FETCH;
        end else begin
          pc_nxt    = seq_pc;
          nxt_state = FETCH;
        end
      end

      HALTED: begin
        nxt_state = HALTED;
      end

      default: begin
        nxt_state = BOOT;
      end
    endcase
  end

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- PC sequencer and fetch controller for the dual-issue instruction fetch stage.
- Each cycle it picks the next fetch address from these sources: reset vector, sequential +8, EX-stage branch redirect, ID-stage jump, and the hazard-unit stall.
- Drives the instruction-memory address, per-slot valid bits and pipeline flush requests.
- Holds the PC across instruction-memory wait cycles and freezes fetch on halt.

Parameters:
- PC_START, 32'h00400020, reset vector loaded into the PC.
- CNT_W, 32, width of the issued-bundle performance counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- stall  in  1  hazard-unit hold; keeps the PC and suppresses fetch_valid.
- br_taken  in  1  EX-stage taken branch.
- br_target  in  32  branch target address.
- jmp_valid  in  1  ID-stage jump (j/jal/jr).
- jmp_target  in  32  jump target address.
- halt  in  1  ID-stage halt (syscall exit).
- imem_ready  in  1  instruction memory returns the bundle this cycle.
- pc  out  32  current fetch PC, byte address, bit 2 significant.
- imem_addr  out  32  {pc[31:3],3'b000}, 8-byte-aligned bundle address.
- slot0_valid  out  1  low word of the bundle is on-path.
- slot1_valid  out  1  high word of the bundle is on-path.
- fetch_valid  out  1  bundle accepted into IF/ID this cycle.
- flush_if_id  out  1  squash IF/ID register.
- flush_id_ex  out  1  squash ID/EX register.
- misalign_err  out  1  sticky; a redirect target had [1:0] != 0.
- state  out  2  debug: 0 BOOT, 1 FETCH, 2 MISS_WAIT, 3 HALTED.
- bundle_cnt  out  CNT_W  count of cycles with fetch_valid=1.

Behaviour:
- Reset (reset=0, asynchronous, takes effect immediately):
  - pc=PC_START, state=BOOT, bundle_cnt=0, misalign_err=0.
  - fetch_valid=0, slot valids=0, flushes=0.
- BOOT: one cycle after reset release; fetch_valid=0; transitions to FETCH unconditionally; the PC is not advanced.
- Next-PC priority, highest first: br_taken, jmp_valid (ignored while stall=1), halt, stall or !imem_ready (hold), sequential.
- Sequential advance: pc <= {pc[31:3],3'b000} + 8, modulo 2^32 (0xFFFFFFF8 wraps to 0x00000000).
- FETCH outputs:
  - slot0_valid = ~pc[2]; slot1_valid = 1.
  - fetch_valid = imem_ready & ~stall & ~br_taken & ~jmp_eff & ~halt.
  - jmp_eff = jmp_valid & ~stall.
- FETCH, imem_ready=0 and no redirect: go to MISS_WAIT; PC held.
- MISS_WAIT:
  - Same outputs as FETCH, but fetch_valid=0 until imem_ready=1.
  - When imem_ready=1: fetch_valid = ~stall; return to FETCH; PC advances if not stalled.
- br_taken=1 in FETCH or MISS_WAIT:
  - Same cycle, combinationally: flush_if_id=1, flush_id_ex=1, fetch_valid=0.
  - Next edge: pc <= {br_target[31:2],2'b00}, state=FETCH. A pending miss is abandoned.
  - Overrides stall, jmp_valid and halt.
- jmp_eff=1 without br_taken: flush_if_id=1, flush_id_ex=0, fetch_valid=0; next edge pc <= {jmp_target[31:2],2'b00}.
- Misaligned target: if an accepted redirect target has [1:0] != 0, misalign_err sets on the next edge and stays set until reset.
- halt=1 with no br_taken/jmp_eff: next edge state=HALTED.
  - HALTED: fetch_valid=0, slot valids=0, PC frozen, all inputs ignored.
  - Only reset leaves HALTED.
- bundle_cnt: increments on every edge where fetch_valid=1; wraps silently at 2^CNT_W.
- Flush outputs are combinational from br_taken/jmp_eff. They are forced to 0 in BOOT and HALTED.

Test Plan:
1. Boot and straight-line fetch. Stimulus: reset=0 for 2 cycles, then release with imem_ready=1 and no other inputs. Required: first cycle state=BOOT, pc=00400020, fetch_valid=0. Then fetch_valid=1 at pc 00400020, 00400028, 00400030. bundle_cnt=3.
2. Stall hold. Stimulus: stall=1 for 2 cycles at pc=00400028. Required: pc stays 00400028, fetch_valid=0. Also assert jmp_valid (target 00400200) during the stall: no flush, PC unchanged. After stall drops, fetch resumes at 00400028 then 00400030.
3. Branch wins over stall and jump. Stimulus: br_taken=1 (target 00400104), jmp_valid=1, stall=1, all in one cycle. Required: same cycle flush_if_id=1, flush_id_ex=1. Next cycle pc=00400104, imem_addr=00400100, slot0_valid=0, slot1_valid=1. Then pc=00400108 with both slots valid.
4. Memory wait and branch abort. Stimulus: imem_ready=0 for 3 cycles at 00400030. Required: state=MISS_WAIT, pc held, fetch_valid=0. Then fetch_valid=1 at 00400030, next pc 00400038. Repeat the wait with br_taken (target 00400400) in its 2nd cycle. Required: state=FETCH, pc=00400400.
5. Halt and mid-operation reset. Stimulus: halt=1 at 00400040, then imem_ready=1 and br_taken pulses. Required: state=HALTED, pc frozen at 00400040, fetch_valid=0 for 5 cycles. Then assert reset=0 between clock edges: pc=00400020 and state=BOOT immediately, bundle_cnt=0.
6. Wrap-around and misalignment. Stimulus: branch to FFFFFFF8, then a jump with target 00400013. Required: pc sequence FFFFFFF8 then 00000000. The jump gives pc=00400010 and misalign_err=1, which stays 1 until reset.
